// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the MIPS register file: default geometry and the zero-register index.
package mips_rf_pkg;
  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_ADDR_W   = 3;
  localparam int unsigned RF_ZERO_IDX = 0;
endpackage

// File: rtl/regfile_scoreboard_busy_table.sv
// Per-register busy scoreboard: reserve at issue, clear at writeback, WAW flag and busy population count.
module rf_busy_table
  import mips_rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter logic        ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [(1<<ADDR_W)-1:0]    busy_vec,
  output logic                      waw_hazard,
  output logic [ADDR_W:0]           busy_count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_count;
  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic             w_inc;
  logic             w_dec;

  assign w_wr_ok  = wr_en  & ~(ZERO_REG & (wr_addr  == ADDR_W'(RF_ZERO_IDX)));
  assign w_rsv_ok = rsv_en & ~(ZERO_REG & (rsv_addr == ADDR_W'(RF_ZERO_IDX)));

  // Reserve is applied after clear so a same-address reserve (newer producer) wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[wr_addr]  = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
  end

  // Count deltas mirror the population change of the busy vector exactly.
  assign w_inc = w_rsv_ok & ~r_busy[rsv_addr];
  assign w_dec = w_wr_ok & r_busy[wr_addr] & ~(w_rsv_ok & (rsv_addr == wr_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_inc && !w_dec)
        r_count <= r_count + (ADDR_W+1)'(1);
      else if (w_dec && !w_inc)
        r_count <= r_count - (ADDR_W+1)'(1);
    end
  end

  assign busy_vec   = r_busy;
  assign waw_hazard = w_rsv_ok & r_busy[rsv_addr];
  assign busy_count = r_count;
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised 2R1W register file with zero register and busy scoreboard.
// Optional same-cycle writeback forwarding: define REGFILE_WRITE_BYPASS_EN.
module regfile_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter logic        ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_register,
  output logic              busy_1,
  output logic              busy_2,
  output logic              waw_hazard,
  output logic [ADDR_W:0]   busy_count
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy_vec;
  logic              w_wr_ok;
  logic              w_rd1_zero;
  logic              w_rd2_zero;

  assign w_wr_ok    = RegWrite & ~(ZERO_REG & (write_register == ADDR_W'(RF_ZERO_IDX)));
  assign w_rd1_zero = ZERO_REG & (read_register_1 == ADDR_W'(RF_ZERO_IDX));
  assign w_rd2_zero = ZERO_REG & (read_register_2 == ADDR_W'(RF_ZERO_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[write_register] <= write_data;
    end
  end

  rf_busy_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (RegWrite),
    .wr_addr    (write_register),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_register),
    .busy_vec   (w_busy_vec),
    .waw_hazard (waw_hazard),
    .busy_count (busy_count)
  );

  always_comb begin
    read_data_1 = w_rd1_zero ? '0 : r_mem[read_register_1];
    read_data_2 = w_rd2_zero ? '0 : r_mem[read_register_2];
    busy_1      = ~w_rd1_zero & w_busy_vec[read_register_1];
    busy_2      = ~w_rd2_zero & w_busy_vec[read_register_2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w_wr_ok && (write_register == read_register_1)) begin
      read_data_1 = write_data;
      busy_1      = 1'b0;
    end
    if (w_wr_ok && (write_register == read_register_2)) begin
      read_data_2 = write_data;
      busy_2      = 1'b0;
    end
`endif
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the 8x16 two-read/one-write register file used by the MIPS datapath. It generalises width and depth, adds a synchronous reset, a hardwired zero register and a per-register busy scoreboard. The decode stage reserves a destination register at issue, and the writeback clears it. Reads are combinational, so decode sees the value and busy status of each operand in the same cycle.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
RegWrite  input  1  writeback enable
write_register  input  ADDR_W  writeback address
write_data  input  DATA_W  writeback data
read_register_1  input  ADDR_W  read port 1 address
read_data_1  output  DATA_W  read port 1 data (combinational)
read_register_2  input  ADDR_W  read port 2 address
read_data_2  output  DATA_W  read port 2 data (combinational)
rsv_en  input  1  reserve destination at issue
rsv_register  input  ADDR_W  register to mark busy
busy_1  output  1  read port 1 register has a pending write
busy_2  output  1  read port 2 register has a pending write
waw_hazard  output  1  rsv_en asserted to a register that is already busy (combinational)
busy_count  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset: on a posedge with rst=1, every register goes to 0 and every busy bit to 0. Next cycle read_data_*=0, busy_*=0, waw_hazard=0 and busy_count=0.
- rst has priority over RegWrite and rsv_en in the same cycle; reset mid-operation discards all pending reservations.
- Write: at posedge, if RegWrite=1 and the address is not the zero register, mem[write_register] <= write_data and busy[write_register] <= 0. The new value is visible on read ports after the edge (1-cycle write latency without bypass).
- Reserve: at posedge, if rsv_en=1 and the address is not the zero register, busy[rsv_register] <= 1.
- Write and reserve to the same address in the same cycle: the data is written and busy ends at 1, because the reserve belongs to a newer producer.
- Write and reserve to different addresses: both take effect.
- waw_hazard = rsv_en & busy[rsv_register] & (rsv_register is not the zero register). It is informational only; the reservation still proceeds.
- Writeback to a register that is not busy: the data is written and busy stays 0. This is legal.
- Zero register (ZERO_REG=1): read_data is always 0, busy is always 0, and writes and reserves to it are dropped. With ZERO_REG=0, register 0 behaves like any other.
- busy_count tracks the population count of busy bits, registered. It changes by -1, 0 or +1 per cycle:
  - +1 when a reserve hits a non-busy register and no clear is applied;
  - -1 when a writeback clears a busy register and no reserve is applied;
  - otherwise unchanged.
  - It never exceeds 2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG=1.
- Both read ports are independent and may address the same register.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- When defined: if RegWrite=1, write_register==read_register_N and the address is not the zero register, then read_data_N=write_data and busy_N=0 in the same cycle. This gives 0-cycle writeback-to-decode forwarding.
- When undefined: reads return stored contents and stored busy bits only; the writer sees its own data one cycle later.

Decomposition:
- Shared package mips_rf_pkg holds default DATA_W/ADDR_W constants and a zero-register index constant.
- A single sub-module rf_busy_table holds the busy vector, reserve/clear priority, waw_hazard and busy_count.
- The data array and read muxing stay in the top module.

Test Plan:
- Reset: assert rst for 1 cycle after random writes -> read regs 0..7 all 0, busy_count=0.
- Basic write/read: RegWrite=1, write_register=4, write_data=20, read_register_1=4, one posedge -> read_data_1=20.
  - Without the macro, read_data_1 is 0 before the edge.
  - With the macro, read_data_1 is 20 before the edge.
- Zero register: write 0xFFFF to reg 0 and reserve reg 0 -> read_data_1=0, busy_1=0, busy_count=0.
- Scoreboard:
  - Reserve reg 3 -> busy_1=1 (read_register_1=3), busy_count=1.
  - Write 7 to reg 3 -> busy_1=0, read_data_1=7, busy_count=0.
- Simultaneous: reg 5 busy; same cycle writeback 9 to reg 5 and rsv_en to reg 5 -> waw_hazard=1 that cycle, then read_data=9, busy=1, busy_count=1.
- Reset priority: rst=1 with RegWrite to reg 2 (data 11) and rsv_en to reg 6 -> reg 2 reads 0, busy for reg 6 is 0.
